// File: rtl/idex_fp.sv
// ID/EX pipeline register for the 16-bit datapath.
// Captures the decoded control fields, forward-PC flag, operands, immediate and
// source register numbers, and presents them to EX one cycle later. A flush
// clears only the control fields, which turns the slot into a bubble. The data
// fields still load so that forwarding compares see sane values.
// Optional feature: define IDEXFP_STALL_EN to add a stall input that holds all
// outputs. Reset and flush both override stall.
module idex_fp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FPC,
    input  logic              flush,
`ifdef IDEXFP_STALL_EN
    input  logic              stall,
`endif
    input  logic [1:0]        WB,
    input  logic [2:0]        M,
    input  logic [3:0]        EX,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] imm_value,
    input  logic [REG_AW-1:0] readReg1,
    input  logic [REG_AW-1:0] readReg2,
    output logic              FPCreg,
    output logic [1:0]        WBreg,
    output logic [2:0]        Mreg,
    output logic [3:0]        EXreg,
    output logic [DATA_W-1:0] op1reg,
    output logic [DATA_W-1:0] op2reg,
    output logic [DATA_W-1:0] imm_valuereg,
    output logic [REG_AW-1:0] readReg1reg,
    output logic [REG_AW-1:0] readReg2reg
);

    logic hold;

`ifdef IDEXFP_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Pipeline register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            FPCreg       <= 1'b0;
            WBreg        <= '0;
            Mreg         <= '0;
            EXreg        <= '0;
            op1reg       <= '0;
            op2reg       <= '0;
            imm_valuereg <= '0;
            readReg1reg  <= '0;
            readReg2reg  <= '0;
        end else if (flush) begin
            // Bubble: kill control, keep data flowing.
            FPCreg       <= 1'b0;
            WBreg        <= '0;
            Mreg         <= '0;
            EXreg        <= '0;
            op1reg       <= op1;
            op2reg       <= op2;
            imm_valuereg <= imm_value;
            readReg1reg  <= readReg1;
            readReg2reg  <= readReg2;
        end else if (!hold) begin
            FPCreg       <= FPC;
            WBreg        <= WB;
            Mreg         <= M;
            EXreg        <= EX;
            op1reg       <= op1;
            op2reg       <= op2;
            imm_valuereg <= imm_value;
            readReg1reg  <= readReg1;
            readReg2reg  <= readReg2;
        end
    end

endmodule

// File: tb/tb_idex_fp.sv
// Scoreboard bench for idex_fp. Stimulus pushes the expected register contents
// into a queue; the monitor pops and compares once per clock after each edge.
module tb_idex_fp;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    typedef struct packed {
        logic          fpc;
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] imm;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
    } fields_t;

    logic    clk = 1'b0;
    logic    reset;
    logic    flush;
    logic    stall;
    fields_t din;

    logic          FPCreg;
    logic [1:0]    WBreg;
    logic [2:0]    Mreg;
    logic [3:0]    EXreg;
    logic [DW-1:0] op1reg;
    logic [DW-1:0] op2reg;
    logic [DW-1:0] imm_valuereg;
    logic [AW-1:0] readReg1reg;
    logic [AW-1:0] readReg2reg;

    fields_t expq[$];
    fields_t model;
    int      compared   = 0;
    int      mismatched = 0;
    int      cyc        = 0;

    always #5 clk = ~clk;

    idex_fp #(
        .DATA_W(DW),
        .REG_AW(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .FPC         (din.fpc),
        .flush       (flush),
`ifdef IDEXFP_STALL_EN
        .stall       (stall),
`endif
        .WB          (din.wb),
        .M           (din.m),
        .EX          (din.ex),
        .op1         (din.op1),
        .op2         (din.op2),
        .imm_value   (din.imm),
        .readReg1    (din.r1),
        .readReg2    (din.r2),
        .FPCreg      (FPCreg),
        .WBreg       (WBreg),
        .Mreg        (Mreg),
        .EXreg       (EXreg),
        .op1reg      (op1reg),
        .op2reg      (op2reg),
        .imm_valuereg(imm_valuereg),
        .readReg1reg (readReg1reg),
        .readReg2reg (readReg2reg)
    );

    // Build an input word: control fields and a data pattern.
    function automatic fields_t mk(input logic f, input logic [1:0] w, input logic [2:0] mm,
                                   input logic [3:0] e, input logic [DW-1:0] d,
                                   input logic [AW-1:0] r);
        fields_t t;
        t.fpc = f; t.wb = w; t.m = mm; t.ex = e;
        t.op1 = d; t.op2 = d; t.imm = d; t.r1 = r; t.r2 = r;
        return t;
    endfunction

    // Apply one cycle of inputs and push what the register must hold after the edge.
    task automatic drive(input logic rst, input logic fl, input logic st, input fields_t v);
        fields_t nxt;
        @(negedge clk);
        reset = rst; flush = fl; stall = st; din = v;
        nxt = v;
        if (rst) begin
            nxt = '0;
        end else if (fl) begin
            nxt.fpc = 1'b0; nxt.wb = '0; nxt.m = '0; nxt.ex = '0;
        end else begin
`ifdef IDEXFP_STALL_EN
            if (st) nxt = model;
`endif
        end
        model = nxt;
        expq.push_back(nxt);
    endtask

    // Monitor: every edge yields one registered word to check.
    initial begin
        fields_t got, exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() != 0) begin
                exp = expq.pop_front();
                got = {FPCreg, WBreg, Mreg, EXreg, op1reg, op2reg, imm_valuereg,
                       readReg1reg, readReg2reg};
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL regs cycle %0d: got fpc=%b wb=%b m=%b ex=%b op1=%h op2=%h imm=%h r1=%h r2=%h, want fpc=%b wb=%b m=%b ex=%b op1=%h op2=%h imm=%h r1=%h r2=%h",
                             cyc, got.fpc, got.wb, got.m, got.ex, got.op1, got.op2, got.imm,
                             got.r1, got.r2, exp.fpc, exp.wb, exp.m, exp.ex, exp.op1, exp.op2,
                             exp.imm, exp.r1, exp.r2);
                end
            end
        end
    end

    initial begin
        fields_t a, b, r;
        int      wait_cnt;
        reset = 1'b0; flush = 1'b0; stall = 1'b0; din = '0; model = '0;

        // Directed cases.
        a = mk(1'b1, 2'b01, 3'b010, 4'b0111, 16'h1111, 4'b1111);
        b = mk(1'b0, 2'b10, 3'b101, 4'b1110, 16'hBBBB, 4'b0101);
        drive(1'b1, 1'b0, 1'b0, a);              // reset with nonzero inputs
        drive(1'b0, 1'b0, 1'b0, a);              // load
        drive(1'b0, 1'b0, 1'b0, b);              // replace in one cycle
        drive(1'b0, 1'b1, 1'b0, b);              // flush
        drive(1'b0, 1'b1, 1'b0, a);              // consecutive bubble
        drive(1'b1, 1'b1, 1'b0, b);              // reset beats flush
        drive(1'b0, 1'b0, 1'b0, a);              // resume after reset
`ifdef IDEXFP_STALL_EN
        drive(1'b0, 1'b0, 1'b1, b);
        drive(1'b0, 1'b0, 1'b1, b);
        drive(1'b0, 1'b0, 1'b1, b);              // held at 1111h
        drive(1'b0, 1'b1, 1'b1, b);              // flush beats stall
        drive(1'b1, 1'b0, 1'b1, b);              // reset beats stall
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = fields_t'({$urandom, $urandom, $urandom});
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), r);
        end
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; stall = 1'b0;

        // Drain with a bounded wait.
        wait_cnt = 0;
        while (expq.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
